eprobe_load_rx: RTL and testbench

EPROBE_LOAD_RX -- requirements
Module: eprobe_load_rx

---
 rtl/eprobe_load_rx_if.sv | 37 +++
 rtl/eprobe_load_rx.sv | 170 +++++++++++++++++
 tb/tb_eprobe_load_rx.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eprobe_load_rx_if.sv
// eprobe_load_rx_if: probe-side load bus, readback port and status
// outputs of the LED enable receiver.
interface eprobe_load_rx_if #(
  parameter int CNT_W = 16
);
  logic [1:0]       probe;
  logic [6:1]       addr;
  logic [2:1]       pix;
  logic             load;
  logic             en_led;
  logic             cnt_clr;
  logic             rd_req;
  logic [9:0]       rd_addr;
  logic             rd_valid;
  logic             rd_data;
  logic [10:0]      en_total;
  logic [CNT_W-1:0] load_count;
  logic [7:0]       seq_err_count;
  logic             sweep_done;
  logic [1:0]       rx_state;

  modport master (
    output probe, addr, pix, load, en_led,
    output cnt_clr, rd_req, rd_addr,
    input  rd_valid, rd_data, en_total,
    input  load_count, seq_err_count,
    input  sweep_done, rx_state
  );

  modport slave (
    input  probe, addr, pix, load, en_led,
    input  cnt_clr, rd_req, rd_addr,
    output rd_valid, rd_data, en_total,
    output load_count, seq_err_count,
    output sweep_done, rx_state
  );
endinterface

// File: rtl/eprobe_load_rx.sv
// eprobe_load_rx: synchronizes probe LED-load strobes, stores a 1024x1
// enable map, counts loads and tracks in-order 0..1023 sweeps.
module eprobe_load_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  eprobe_load_rx_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SWEEP = 2'b01,
    DONE  = 2'b10
  } rx_state_e;

  localparam int DW = 11;

  logic [SYNC_STAGES-1:0][DW-1:0] dsync_q, dsync_d;
  logic [SYNC_STAGES-1:0]         lsync_q, lsync_d;
  logic                           ld_prev_q, ld_prev_d;

  logic [1023:0]    mem_q, mem_d;
  logic [10:0]      en_total_q, en_total_d;
  logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
  logic [7:0]       seq_err_q, seq_err_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_data_q, rd_data_d;
  rx_state_e        state_q, state_d;
  logic [9:0]       exp_idx_q, exp_idx_d;

  logic [DW-1:0] s_last;
  logic [9:0]    led_idx;
  logic          wr_en;
  logic          edge_det;
  logic          old_bit;

  assign s_last   = dsync_q[SYNC_STAGES-1];
  assign led_idx  = s_last[10:1];
  assign wr_en    = s_last[0];
  assign edge_det = lsync_q[SYNC_STAGES-1] & ~ld_prev_q;
  assign old_bit  = mem_q[led_idx];

  // Shift probe inputs through the synchronizer chains.
  always_comb begin
    dsync_d = {dsync_q[SYNC_STAGES-2:0],
               {bus.probe, bus.addr, bus.pix, bus.en_led}};
    lsync_d = {lsync_q[SYNC_STAGES-2:0], bus.load};
    ld_prev_d = lsync_q[SYNC_STAGES-1];
  end

  // Enable map write and running enabled-LED total.
  always_comb begin
    mem_d      = mem_q;
    en_total_d = en_total_q;
    if (edge_det) begin
      mem_d[led_idx] = wr_en;
      if (wr_en && !old_bit)
        en_total_d = en_total_q + 11'd1;
      else if (!wr_en && old_bit)
        en_total_d = en_total_q - 11'd1;
    end
  end

  // Write-first readback, one cycle latency.
  always_comb begin
    rd_valid_d = bus.rd_req;
    rd_data_d  = rd_data_q;
    if (bus.rd_req) begin
      if (edge_det && led_idx == bus.rd_addr)
        rd_data_d = wr_en;
      else
        rd_data_d = mem_q[bus.rd_addr];
    end
  end

  // Saturating load counter; clear wins over a coincident edge.
  always_comb begin
    load_cnt_d = load_cnt_q;
    if (bus.cnt_clr)
      load_cnt_d = '0;
    else if (edge_det && load_cnt_q != '1)
      load_cnt_d = load_cnt_q + 1'b1;
  end

  // Sweep tracker next state and sequence-error counting.
  always_comb begin
    state_d   = state_q;
    exp_idx_d = exp_idx_q;
    seq_err_d = seq_err_q;
    unique case (state_q)
      IDLE: begin
        if (edge_det && led_idx == 10'd0) begin
          state_d   = SWEEP;
          exp_idx_d = 10'd1;
        end
      end
      SWEEP: begin
        if (edge_det) begin
          if (led_idx == exp_idx_q) begin
            if (exp_idx_q == 10'd1023) begin
              state_d   = DONE;
              exp_idx_d = 10'd0;
            end else begin
              exp_idx_d = exp_idx_q + 10'd1;
            end
          end else begin
            if (seq_err_q != 8'hFF)
              seq_err_d = seq_err_q + 8'd1;
            if (led_idx == 10'd0) begin
              exp_idx_d = 10'd1;
            end else begin
              state_d   = IDLE;
              exp_idx_d = 10'd0;
            end
          end
        end
      end
      DONE: begin
        state_d   = IDLE;
        exp_idx_d = 10'd0;
      end
      default: begin
        state_d   = IDLE;
        exp_idx_d = 10'd0;
      end
    endcase
    if (bus.cnt_clr)
      seq_err_d = 8'd0;
  end

  // State registers; load chain resets high to mask a held strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      dsync_q    <= '0;
      lsync_q    <= '1;
      ld_prev_q  <= 1'b1;
      mem_q      <= '0;
      en_total_q <= '0;
      load_cnt_q <= '0;
      seq_err_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 1'b0;
      state_q    <= IDLE;
      exp_idx_q  <= '0;
    end else begin
      dsync_q    <= dsync_d;
      lsync_q    <= lsync_d;
      ld_prev_q  <= ld_prev_d;
      mem_q      <= mem_d;
      en_total_q <= en_total_d;
      load_cnt_q <= load_cnt_d;
      seq_err_q  <= seq_err_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      state_q    <= state_d;
      exp_idx_q  <= exp_idx_d;
    end
  end

  assign bus.rd_valid      = rd_valid_q;
  assign bus.rd_data       = rd_data_q;
  assign bus.en_total      = en_total_q;
  assign bus.load_count    = load_cnt_q;
  assign bus.seq_err_count = seq_err_q;
  assign bus.sweep_done    = (state_q == DONE);
  assign bus.rx_state      = state_q;

endmodule

// File: tb/tb_eprobe_load_rx.sv
// tb_eprobe_load_rx: directed checks of writes, readback, sweep
// tracking, counter saturation/clear and reset behaviour.
module tb_eprobe_load_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  eprobe_load_rx_if #(.CNT_W(16)) bus ();
  eprobe_load_rx_if #(.CNT_W(4))  sif ();

  assign sif.probe   = bus.probe;
  assign sif.addr    = bus.addr;
  assign sif.pix     = bus.pix;
  assign sif.load    = bus.load;
  assign sif.en_led  = bus.en_led;
  assign sif.cnt_clr = bus.cnt_clr;
  assign sif.rd_req  = bus.rd_req;
  assign sif.rd_addr = bus.rd_addr;

  eprobe_load_rx #(.SYNC_STAGES(2), .CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  eprobe_load_rx #(.SYNC_STAGES(2), .CNT_W(4)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always @(posedge clk)
    if (!rst && bus.sweep_done) done_cnt++;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_led(input logic [9:0] a, input logic en);
    bus.probe  = a[9:8];
    bus.addr   = a[7:2];
    bus.pix    = a[1:0];
    bus.en_led = en;
  endtask

  // Pulse load for one cycle; the write lands two cycles later.
  task automatic write_led(input logic [9:0] a, input logic en);
    set_led(a, en);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    tick(2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(3);
    done_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    if (bus.en_total !== 11'd0 || bus.load_count !== 16'd0 ||
        bus.seq_err_count !== 8'd0 || bus.rd_valid !== 1'b0 ||
        bus.rd_data !== 1'b0 || bus.sweep_done !== 1'b0 ||
        bus.rx_state !== 2'b00) begin
      $display("FAIL reset_state: tot=%0d cnt=%0d err=%0d rv=%b rd=%b sd=%b st=%0d want all 0",
               bus.en_total, bus.load_count, bus.seq_err_count,
               bus.rd_valid, bus.rd_data, bus.sweep_done, bus.rx_state);
      n_fail++;
    end
    n_chk++;
    rst = 1'b0;
    tick(3);
  endtask

  task automatic test_single_write();
    do_reset();
    write_led(10'h2A5, 1'b1);
    if (bus.en_total !== 11'd1 || bus.load_count !== 16'd1) begin
      $display("FAIL single_write: tot=%0d cnt=%0d want 1 1",
               bus.en_total, bus.load_count);
      n_fail++;
    end
    n_chk++;
    bus.rd_addr = 10'h2A5;
    bus.rd_req  = 1'b1;
    tick();
    bus.rd_req  = 1'b0;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 1'b1) begin
      $display("FAIL single_read: rv=%b rd=%b want 1 1",
               bus.rd_valid, bus.rd_data);
      n_fail++;
    end
    n_chk++;
    bus.rd_addr = 10'h2A4;
    bus.rd_req  = 1'b1;
    tick();
    bus.rd_req  = 1'b0;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 1'b0) begin
      $display("FAIL neighbour_read: rv=%b rd=%b want 1 0",
               bus.rd_valid, bus.rd_data);
      n_fail++;
    end
    n_chk++;
    tick();
    if (bus.rd_valid !== 1'b0) begin
      $display("FAIL rd_valid_drop: got %b want 0", bus.rd_valid);
      n_fail++;
    end
    n_chk++;
  endtask

  task automatic test_full_sweep();
    do_reset();
    for (int i = 0; i < 1024; i++)
      write_led(10'(i), 1'b1);
    tick(2);
    if (done_cnt !== 1) begin
      $display("FAIL sweep_done_pulses: got %0d want 1", done_cnt);
      n_fail++;
    end
    n_chk++;
    if (bus.en_total !== 11'd1024 || bus.load_count !== 16'd1024 ||
        bus.seq_err_count !== 8'd0 || bus.rx_state !== 2'b00) begin
      $display("FAIL sweep_totals: tot=%0d cnt=%0d err=%0d st=%0d want 1024 1024 0 0",
               bus.en_total, bus.load_count, bus.seq_err_count,
               bus.rx_state);
      n_fail++;
    end
    n_chk++;
  endtask

  task automatic test_sweep_break();
    do_reset();
    write_led(10'd0, 1'b1);
    write_led(10'd1, 1'b1);
    write_led(10'd2, 1'b1);
    if (bus.rx_state !== 2'b01) begin
      $display("FAIL sweep_running: st=%0d want 1", bus.rx_state);
      n_fail++;
    end
    n_chk++;
    write_led(10'd5, 1'b1);
    if (bus.seq_err_count !== 8'd1 || bus.rx_state !== 2'b00) begin
      $display("FAIL sweep_break: err=%0d st=%0d want 1 0",
               bus.seq_err_count, bus.rx_state);
      n_fail++;
    end
    n_chk++;
    write_led(10'd0, 1'b1);
    write_led(10'd1, 1'b1);
    if (bus.rx_state !== 2'b01 || bus.seq_err_count !== 8'd1) begin
      $display("FAIL sweep_restart: st=%0d err=%0d want 1 1",
               bus.rx_state, bus.seq_err_count);
      n_fail++;
    end
    n_chk++;
  endtask

  task automatic test_overwrite();
    logic [10:0] want [3];
    logic        val  [3];
    want = '{11'd1, 11'd1, 11'd0};
    val  = '{1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      write_led(10'h010, val[i]);
      if (bus.en_total !== want[i]) begin
        $display("FAIL overwrite_%0d: tot=%0d want %0d",
                 i, bus.en_total, want[i]);
        n_fail++;
      end
      n_chk++;
    end
    if (bus.load_count !== 16'd3) begin
      $display("FAIL overwrite_count: got %0d want 3", bus.load_count);
      n_fail++;
    end
    n_chk++;
  endtask

  // Raise load, then present rd_req/cnt_clr in the write cycle.
  task automatic collide(input logic [9:0] a, input logic en,
                         input logic rd, input logic clr);
    set_led(a, en);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
    tick();
    bus.rd_addr = a;
    bus.rd_req  = rd;
    bus.cnt_clr = clr;
    tick();
    bus.rd_req  = 1'b0;
    bus.cnt_clr = 1'b0;
  endtask

  task automatic test_collision_sat();
    do_reset();
    collide(10'h155, 1'b1, 1'b1, 1'b0);
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 1'b1) begin
      $display("FAIL collide_set: rv=%b rd=%b want 1 1",
               bus.rd_valid, bus.rd_data);
      n_fail++;
    end
    n_chk++;
    tick();
    collide(10'h155, 1'b0, 1'b1, 1'b0);
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 1'b0) begin
      $display("FAIL collide_clear: rv=%b rd=%b want 1 0",
               bus.rd_valid, bus.rd_data);
      n_fail++;
    end
    n_chk++;
    tick();
    for (int i = 0; i < 18; i++)
      write_led(10'(100 + i), 1'b1);
    if (sif.load_count !== 4'd15 || bus.load_count !== 16'd20) begin
      $display("FAIL saturate: sat=%0d main=%0d want 15 20",
               sif.load_count, bus.load_count);
      n_fail++;
    end
    n_chk++;
    collide(10'h3FF, 1'b1, 1'b0, 1'b1);
    if (bus.load_count !== 16'd0 || sif.load_count !== 4'd0 ||
        bus.en_total !== 11'd19) begin
      $display("FAIL clr_with_load: main=%0d sat=%0d tot=%0d want 0 0 19",
               bus.load_count, sif.load_count, bus.en_total);
      n_fail++;
    end
    n_chk++;
  endtask

  task automatic test_reset_cases();
    do_reset();
    bus.load = 1'b1;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(4);
    bus.load = 1'b0;
    tick(3);
    if (bus.load_count !== 16'd0) begin
      $display("FAIL load_held_reset: cnt=%0d want 0", bus.load_count);
      n_fail++;
    end
    n_chk++;
    for (int i = 0; i < 10; i++)
      write_led(10'(i), 1'b1);
    if (bus.rx_state !== 2'b01 || bus.en_total !== 11'd10) begin
      $display("FAIL mid_sweep_pre: st=%0d tot=%0d want 1 10",
               bus.rx_state, bus.en_total);
      n_fail++;
    end
    n_chk++;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(3);
    if (bus.rx_state !== 2'b00 || bus.en_total !== 11'd0 ||
        bus.load_count !== 16'd0 || bus.seq_err_count !== 8'd0 ||
        bus.sweep_done !== 1'b0 || done_cnt !== 0) begin
      $display("FAIL mid_sweep_reset: st=%0d tot=%0d cnt=%0d err=%0d sd=%b pulses=%0d want all 0",
               bus.rx_state, bus.en_total, bus.load_count,
               bus.seq_err_count, bus.sweep_done, done_cnt);
      n_fail++;
    end
    n_chk++;
    bus.rd_addr = 10'd3;
    bus.rd_req  = 1'b1;
    tick();
    bus.rd_req  = 1'b0;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 1'b0) begin
      $display("FAIL mem_cleared: rv=%b rd=%b want 1 0",
               bus.rd_valid, bus.rd_data);
      n_fail++;
    end
    n_chk++;
  endtask

  initial begin
    bus.probe   = '0;
    bus.addr    = '0;
    bus.pix     = '0;
    bus.load    = 1'b0;
    bus.en_led  = 1'b0;
    bus.cnt_clr = 1'b0;
    bus.rd_req  = 1'b0;
    bus.rd_addr = '0;
    test_reset();
    test_single_write();
    test_full_sweep();
    test_sweep_break();
    test_overwrite();
    test_collision_sat();
    test_reset_cases();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
